perceptron_seq: RTL and testbench

PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

---
 rtl/perceptron_seq_if.sv | 22 ++
 rtl/perceptron_seq.sv | 118 +++++++++++
 tb/tb_perceptron_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/perceptron_seq_if.sv
// Register-file write port, evaluation handshake and result bus of perceptron_seq.
interface perceptron_seq_if;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       wr_err;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, result, wr_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, result, wr_err
  );
endinterface

// File: rtl/perceptron_seq.sv
// Sequential perceptron: bias + sum(X[i]*W[i]) through one shared 9x8 signed
// multiplier, one product per cycle, followed by ReLU and saturation to 8 bits.
module perceptron_seq #(
  parameter int N_IN  = 4,
  parameter int ACC_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  perceptron_seq_if.slave bus
);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic [4:0] N_IN_V = 5'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);

  typedef enum logic [1:0] {IDLE, MAC, ACT} state_e;

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     wr_err_q;
  logic [7:0]               result_q;
  logic [7:0]               x_q [N_IN];
  logic signed [7:0]        w_q [N_IN];
  logic signed [7:0]        bias_q;

  logic                     wr_accept_d;
  logic                     wr_err_d;
  logic                     addr_ok;
  logic [IDX_W-1:0]         wr_idx;
  logic signed [16:0]       prod;
  logic [7:0]               result_d;

  assign addr_ok = {1'b0, bus.wr_addr} < N_IN_V;
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];
  // X is unsigned, so it gets a zero MSB before the signed multiply.
  assign prod    = $signed({1'b0, x_q[idx_q]}) * w_q[idx_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_accept_d = 1'b0;
    wr_err_d    = 1'b0;
    if (bus.wr_en) begin
      if (busy_q || bus.wr_sel == 2'd3 || (bus.wr_sel != 2'd2 && !addr_ok))
        wr_err_d = 1'b1;
      else
        wr_accept_d = 1'b1;
    end
  end

  always_comb begin
    result_d = acc_q[7:0];
    if (acc_q[ACC_W-1] || acc_q == '0) result_d = 8'd0;
    else if (acc_q > SAT_MAX)          result_d = 8'd255;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values (e.g. start sees the old bias).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      result_q <= '0;
      bias_q   <= '0;
      // NOTE: the register file is reset explicitly because a reset must
      // leave all weights, inputs and bias at zero.
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= wr_err_d;

      if (wr_accept_d) begin
        case (bus.wr_sel)
          2'd0:    x_q[wr_idx] <= bus.wr_data;
          2'd1:    w_q[wr_idx] <= bus.wr_data;
          default: bias_q      <= bus.wr_data;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q   <= ACC_W'(bias_q);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= ACT;
        end
        ACT: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: expected results are queued at start and
// compared by an independent monitor whenever done pulses.
module tb_perceptron_seq;
  localparam int N_IN = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb_q [$];

  perceptron_seq_if bus ();

  perceptron_seq #(.N_IN(N_IN), .ACC_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) check("unexpected_done", bus.done, 0);
      else                  check("result", bus.result, sb_q.pop_front());
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [3:0] addr,
                    input logic [7:0] data, input logic exp_err);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("wr_err", bus.wr_err, exp_err);
  endtask

  task automatic set_vec(input logic [7:0] xs [4], input logic [7:0] ws [4],
                         input logic [7:0] b);
    for (int i = 0; i < N_IN; i++) begin
      wr(2'd0, 4'(i), xs[i], 1'b0);
      wr(2'd1, 4'(i), ws[i], 1'b0);
    end
    wr(2'd2, 4'd0, b, 1'b0);
  endtask

  // Counts negedges with busy high; returns after busy falls or the bound expires.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic finish_eval(input logic [7:0] exp, input int busy_seen);
    int cyc;
    wait_idle(cyc);
    check("busy_len", cyc + busy_seen, N_IN + 1);
    check("done_at_idle", bus.done, 1);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("result_hold", bus.result, exp);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic eval(input logic [7:0] exp);
    @(negedge clk);
    bus.start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    finish_eval(exp, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_wr_err", bus.wr_err, 0);
    rst = 1'b0;

    // 2*4 + 3*9 = 35
    set_vec('{8'd2, 8'd3, 8'd0, 8'd0}, '{8'd4, 8'd9, 8'd0, 8'd0}, 8'd0);
    eval(8'd35);

    // Write and second start during MAC are rejected; result unaffected.
    @(negedge clk);
    bus.start = 1'b1;
    sb_q.push_back(8'd35);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_addr = 4'd0; bus.wr_data = 8'd99;
    bus.start = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    check("busy_wr_err", bus.wr_err, 1);
    finish_eval(8'd35, 2);
    eval(8'd35);

    // Out-of-range address and reserved target.
    wr(2'd0, 4'd7, 8'd55, 1'b1);
    wr(2'd1, 4'd4, 8'd55, 1'b1);
    wr(2'd3, 4'd0, 8'd55, 1'b1);
    eval(8'd35);

    // 5 + 10*(-4) = -35 -> ReLU 0
    set_vec('{8'd10, 8'd0, 8'd0, 8'd0}, '{8'hFC, 8'd0, 8'd0, 8'd0}, 8'd5);
    eval(8'd0);

    // 100 + 5 - 12 + 21 - 32 = 82
    set_vec('{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'hFA, 8'd7, 8'hF8}, 8'd100);
    eval(8'd82);

    // Bias write in the start cycle: evaluation still uses bias 100.
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = 2'd2; bus.wr_addr = 4'd0; bus.wr_data = 8'd0;
    bus.start = 1'b1;
    sb_q.push_back(8'd82);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    check("idle_wr_ok", bus.wr_err, 0);
    finish_eval(8'd82, 0);
    eval(8'd0);   // bias now 0: -18 -> 0

    // Exactly 255 passes through; 256 saturates.
    set_vec('{8'd255, 8'd0, 8'd0, 8'd0}, '{8'd1, 8'd0, 8'd0, 8'd0}, 8'd0);
    eval(8'd255);
    set_vec('{8'd128, 8'd0, 8'd0, 8'd0}, '{8'd2, 8'd0, 8'd0, 8'd0}, 8'd0);
    eval(8'd255);
    set_vec('{8'd1, 8'd0, 8'd0, 8'd0}, '{8'd1, 8'd0, 8'd0, 8'd0}, 8'd0);
    eval(8'd1);

    // 4*255*127 + 127 -> 255
    set_vec('{8'd255, 8'd255, 8'd255, 8'd255}, '{8'd127, 8'd127, 8'd127, 8'd127}, 8'd127);
    eval(8'd255);

    // Reset on the second MAC cycle aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_done", bus.done, 0);
    repeat (8) @(negedge clk);
    check("abort_idle", bus.busy, 0);
    eval(8'd0);

    wait_idle(cyc);
    check("final_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
